// File: rtl/myoquad_array.sv
// myoquad_array: N-channel differential quadrature decoder with Avalon-MM register access.
// Per channel: 2-FF sync, glitch filter, 4x decode, windowed velocity, fault/illegal error counting.
module myoquad_array #(
   parameter int NUM_CH     = 4,
   parameter int POS_W      = 32,
   parameter int VEL_W      = 16,
   parameter int FILT_LEN   = 4,
   parameter int VEL_PERIOD = 50000,
   parameter int AW         = $clog2(NUM_CH) + 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [AW-1:0]     address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [NUM_CH-1:0] quad_apos,
   input  logic [NUM_CH-1:0] quad_aneg,
   input  logic [NUM_CH-1:0] quad_bpos,
   input  logic [NUM_CH-1:0] quad_bneg,
   output logic              irq
);
   localparam int WW = $clog2(VEL_PERIOD + 1);
   localparam logic signed [POS_W-1:0] VMAX = {{(POS_W-VEL_W+1){1'b0}}, {(VEL_W-1){1'b1}}};
   localparam logic signed [POS_W-1:0] VMIN = ~VMAX;
   logic [WW-1:0]     wcnt;
   logic              tc;
   logic [1:0]        sv;
   logic [AW-1:0]     ch;
   logic [1:0]        r;
   logic [31:0]       rdv [NUM_CH];
   logic [31:0]       rsel;
   logic [NUM_CH-1:0] ie;
   assign ch = address >> 2;
   assign r  = address[1:0];
   assign tc = wcnt == WW'(VEL_PERIOD - 1);
   // sv[1] marks the synchronisers as holding real pin samples rather than reset zeros
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wcnt     <= '0;
         sv       <= '0;
         irq      <= 1'b0;
         readdata <= '0;
      end else begin
         wcnt <= tc ? '0 : wcnt + WW'(1);
         sv   <= {sv[0], 1'b1};
         irq  <= |ie;
         if (read) readdata <= rsel;
      end
   always_comb begin
      rsel = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (ch == AW'(i)) rsel = rdv[i];
   end
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [3:0]              s1, s2, ca, cb;
      logic                    fa, fb, vld, fq, ediff, eill;
      logic [1:0]              prev, cur, chg, inc;
      logic [POS_W-1:0]        pos, rbase;
      logic signed [POS_W-1:0] d;
      logic [VEL_W-1:0]        vel, vnx;
      logic [15:0]             ecnt, ebase;
      logic [16:0]             esum;
      logic [2:0]              ctrl;
      logic                    sel, wpos, werr, wctl, fault, dr, il, step, up;
      assign sel   = ch == AW'(g);
      assign wpos  = write & sel & (r == 2'd0);
      assign werr  = write & sel & (r == 2'd2);
      assign wctl  = write & sel & (r == 2'd3);
      assign cur   = {fa, fb};
      assign chg   = prev ^ cur;
      assign il    = vld & (&chg);
      assign step  = vld & (^chg);
      assign up    = prev[1] ^ cur[0] ^ ctrl[1];
      assign fault = sv[1] & ((s2[3] == s2[2]) | (s2[1] == s2[0]));
      assign dr    = fault & ~fq;
      assign inc   = {1'b0, dr} + {1'b0, il};
      assign ebase = (werr & writedata[31]) ? '0 : ecnt;
      assign esum  = {1'b0, ebase} + {15'b0, inc};
      assign d     = pos - rbase;
      assign vnx   = d > VMAX ? VMAX[VEL_W-1:0] : d < VMIN ? VMIN[VEL_W-1:0] : d[VEL_W-1:0];
      assign ie[g] = ctrl[2] & (ediff | eill);
      assign rdv[g] = r == 2'd0 ? 32'($signed(pos)) :
                      r == 2'd1 ? 32'($signed(vel)) :
                      r == 2'd2 ? {ecnt, 14'b0, eill, ediff} : {29'b0, ctrl};
      always_ff @(posedge clk or negedge reset_n)
         if (!reset_n) begin
            s1    <= '0;
            s2    <= '0;
            ca    <= '0;
            cb    <= '0;
            fa    <= 1'b0;
            fb    <= 1'b0;
            prev  <= '0;
            vld   <= 1'b0;
            fq    <= 1'b0;
            pos   <= '0;
            rbase <= '0;
            vel   <= '0;
            ediff <= 1'b0;
            eill  <= 1'b0;
            ecnt  <= '0;
            ctrl  <= '0;
         end else begin
            s1 <= {quad_apos[g], quad_aneg[g], quad_bpos[g], quad_bneg[g]};
            s2 <= s1;
            if (s2[3] == fa) ca <= '0;
            else if (ca == 4'(FILT_LEN - 1)) begin
               fa <= s2[3];
               ca <= '0;
            end else ca <= ca + 4'd1;
            if (s2[1] == fb) cb <= '0;
            else if (cb == 4'(FILT_LEN - 1)) begin
               fb <= s2[1];
               cb <= '0;
            end else cb <= cb + 4'd1;
            // decode arms only once both filters agree with real pin levels
            prev <= cur;
            vld  <= vld | (sv[1] & (s2[3] == fa) & (s2[1] == fb));
            fq   <= fault;
            if (wpos) pos <= POS_W'(writedata);
            else if (ctrl[0] & step) pos <= up ? pos + POS_W'(1) : pos - POS_W'(1);
            if (wpos) rbase <= POS_W'(writedata);
            else if (tc) rbase <= pos;
            if (tc) vel <= vnx;
            ediff <= (ediff & ~(werr & writedata[0])) | dr;
            eill  <= (eill & ~(werr & writedata[1])) | il;
            ecnt  <= esum[16] ? '1 : esum[15:0];
            if (wctl) ctrl <= writedata[2:0];
         end
   end
endmodule

// File: tb/tb_myoquad_array.sv
// tb_myoquad_array: directed stimulus with a queue scoreboard checked by a free-running monitor.
// A second instance (narrow position/velocity, 3 channels) covers saturation, sign extension and unmapped channels.
module tb_myoquad_array;
   logic        clk = 0, reset_n = 0;
   logic [3:0]  address = 0;
   logic [31:0] writedata = 0;
   logic        read = 0, write = 0, rd2 = 0, wr2 = 0, iv = 0;
   logic [3:0]  ap = 0, an = '1, bp = 0, bn = '1;
   logic [2:0]  ap2 = 0, an2 = '1, bp2 = 0, bn2 = '1;
   logic [31:0] readdata, readdata2;
   logic        irq, irq2;
   logic        rv1 = 0, rv2 = 0, iv_d = 0;
   int          n_cmp = 0, n_bad = 0, cyc;
   int          ph [4];
   int          ph2 [3];
   logic [31:0] eq [$];
   string       nq [$];

   always #5 clk = ~clk;

   myoquad_array #(.NUM_CH(4), .POS_W(32), .VEL_W(16), .FILT_LEN(4), .VEL_PERIOD(3000)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(readdata), .quad_apos(ap), .quad_aneg(an),
      .quad_bpos(bp), .quad_bneg(bn), .irq(irq));

   myoquad_array #(.NUM_CH(3), .POS_W(16), .VEL_W(8), .FILT_LEN(1), .VEL_PERIOD(1000)) u8 (
      .clk(clk), .reset_n(reset_n), .address(address), .read(rd2), .write(wr2),
      .writedata(writedata), .readdata(readdata2), .quad_apos(ap2), .quad_aneg(an2),
      .quad_bpos(bp2), .quad_bneg(bn2), .irq(irq2));

   always @(posedge clk or negedge reset_n)
      if (!reset_n) cyc <= 0;
      else cyc <= cyc + 1;

   always @(posedge clk) begin
      rv1  <= read;
      rv2  <= rd2;
      iv_d <= iv;
   end

   always @(negedge clk) begin : mon
      logic [31:0] act, e;
      string nm;
      if (rv1 || rv2 || iv_d) begin
         act = rv1 ? readdata : rv2 ? readdata2 : {31'b0, irq};
         n_cmp++;
         if (eq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output actual=%h", act);
         end else begin
            e  = eq.pop_front();
            nm = nq.pop_front();
            if (act !== e) begin
               n_bad++;
               $display("FAIL %s actual=%h required=%h", nm, act, e);
            end
         end
      end
   end

   initial begin
      #900us;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   function automatic logic [1:0] gray(input int p);
      case (p & 3)
         0: return 2'b00;
         1: return 2'b01;
         2: return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drv(input bit d, input int c, input logic [1:0] ab);
      if (!d) begin
         ap[c] = ab[1]; an[c] = ~ab[1]; bp[c] = ab[0]; bn[c] = ~ab[0];
      end else begin
         ap2[c] = ab[1]; an2[c] = ~ab[1]; bp2[c] = ab[0]; bn2[c] = ~ab[0];
      end
   endtask

   task automatic steps(input bit d, input int c, input int dir, input int n, input int hold);
      for (int k = 0; k < n; k++) begin
         if (!d) begin
            ph[c] += dir;
            drv(d, c, gray(ph[c]));
         end else begin
            ph2[c] += dir;
            drv(d, c, gray(ph2[c]));
         end
         idle(hold);
      end
   endtask

   task automatic wr(input bit d, input int a, input logic [31:0] v);
      address = 4'(a); writedata = v;
      if (d) wr2 = 1; else write = 1;
      @(negedge clk);
      write = 0; wr2 = 0;
   endtask

   task automatic rd(input bit d, input int a, input logic [31:0] e, input string nm);
      address = 4'(a);
      if (d) rd2 = 1; else read = 1;
      eq.push_back(e); nq.push_back(nm);
      @(negedge clk);
      read = 0; rd2 = 0;
   endtask

   task automatic chk_irq(input logic e, input string nm);
      iv = 1;
      eq.push_back({31'b0, e}); nq.push_back(nm);
      @(negedge clk);
      iv = 0;
   endtask

   task automatic wait_win(input int vp, input int off);
      for (int k = 0; k < 2 * vp && (cyc % vp) != off; k++) @(negedge clk);
   endtask

   initial begin
      for (int c = 0; c < 4; c++) ph[c] = 0;
      for (int c = 0; c < 3; c++) ph2[c] = 0;
      idle(3);
      reset_n = 1;
      idle(10);
      for (int a = 0; a < 16; a++) rd(0, a, 0, $sformatf("rst_reg%0d", a));
      chk_irq(0, "rst_irq");
      for (int c = 0; c < 4; c++) wr(0, c * 4 + 3, 5);
      rd(0, 7, 5, "ctrl1_rb");
      // T1: 100 forward steps on ch0
      steps(0, 0, 1, 100, 6);
      idle(10);
      rd(0, 0, 100, "t1_pos0");
      rd(0, 4, 0, "t1_pos1");
      rd(0, 8, 0, "t1_pos2");
      rd(0, 12, 0, "t1_pos3");
      // T2: wrap at the signed boundary
      wr(0, 4, 32'h7FFF_FFFF);
      steps(0, 1, 1, 1, 10);
      rd(0, 4, 32'h8000_0000, "t2_wrap_up");
      steps(0, 1, -1, 1, 10);
      rd(0, 4, 32'h7FFF_FFFF, "t2_wrap_down");
      address = 4; writedata = 32'h55; read = 1; write = 1;
      eq.push_back(32'h7FFF_FFFF); nq.push_back("rw_pre_value");
      @(negedge clk);
      read = 0; write = 0;
      rd(0, 4, 32'h55, "rw_post_value");
      // T3: 3-cycle glitch on ch2 A is rejected
      drv(0, 2, 2'b10);
      idle(3);
      drv(0, 2, 2'b00);
      idle(15);
      rd(0, 8, 0, "t3_pos2");
      rd(0, 10, 0, "t3_err2");
      // T4: illegal jumps on ch3
      drv(0, 3, 2'b11); ph[3] = 2;
      idle(15);
      rd(0, 14, 32'h0001_0002, "t4_err3");
      rd(0, 12, 0, "t4_pos3");
      chk_irq(1, "t4_irq_set");
      wr(0, 14, 2);
      idle(2);
      chk_irq(0, "t4_irq_clr");
      rd(0, 14, 32'h0001_0000, "t4_err3_w1c");
      drv(0, 3, 2'b00); ph[3] = 0;
      idle(15);
      rd(0, 14, 32'h0002_0002, "t4_err3_second");
      drv(0, 3, 2'b11); ph[3] = 2;
      idle(6);
      wr(0, 14, 2);
      idle(10);
      rd(0, 14, 32'h0003_0002, "t4_w1c_vs_new_err");
      wr(0, 14, 32'h8000_0002);
      rd(0, 14, 0, "t4_err3_clear_all");
      // T5: differential fault on ch0, counted on the edge only
      steps(0, 0, 1, 2, 6);
      ap[0] = 1; an[0] = 1;
      idle(20);
      rd(0, 2, 32'h0001_0001, "t5_err0");
      chk_irq(1, "t5_irq");
      idle(20);
      rd(0, 2, 32'h0001_0001, "t5_err0_edge_only");
      rd(0, 0, 102, "t5_pos0_faulted");
      an[0] = 0;
      idle(5);
      wr(0, 2, 32'h8000_0001);
      idle(2);
      rd(0, 2, 0, "t5_err0_clear");
      chk_irq(0, "t5_irq_clr");
      wait_win(3000, 5);
      steps(0, 0, 1, 400, 5);
      wait_win(3000, 20);
      rd(0, 1, 400, "t5_vel0");
      rd(0, 0, 502, "t5_pos0");
      idle(5);
      wait_win(3000, 20);
      rd(0, 1, 0, "t5_vel0_idle");
      // narrow instance: velocity saturation, direction invert, sign extension, unmapped channel
      wr(1, 3, 1);
      wait_win(1000, 5);
      steps(1, 0, 1, 200, 2);
      wait_win(1000, 20);
      rd(1, 1, 32'h0000_007F, "u8_vel_sat_pos");
      idle(5);
      wait_win(1000, 5);
      steps(1, 0, -1, 200, 2);
      wait_win(1000, 20);
      rd(1, 1, 32'hFFFF_FF80, "u8_vel_sat_neg");
      rd(1, 0, 0, "u8_pos_back");
      wr(1, 3, 3);
      steps(1, 0, 1, 1, 2);
      idle(8);
      rd(1, 0, 32'hFFFF_FFFF, "u8_invert");
      wr(1, 3, 1);
      wr(1, 0, 32'h7FFF);
      steps(1, 0, 1, 1, 2);
      idle(8);
      rd(1, 0, 32'hFFFF_8000, "u8_pos_sext_wrap");
      wr(1, 12, 32'h1234);
      rd(1, 12, 0, "u8_unmapped_pos");
      rd(1, 14, 0, "u8_unmapped_err");
      // T6: reset in the middle of motion
      steps(0, 0, 1, 3, 6);
      ph[0]++;
      drv(0, 0, gray(ph[0]));
      idle(2);
      reset_n = 0;
      idle(3);
      reset_n = 1;
      idle(20);
      for (int a = 0; a < 16; a++) rd(0, a, 0, $sformatf("t6_reg%0d", a));
      chk_irq(0, "t6_irq");
      rd(1, 0, 0, "t6_u8_pos");
      wr(0, 3, 1);
      idle(10);
      rd(0, 0, 0, "t6_no_spurious_pos");
      rd(0, 2, 0, "t6_no_spurious_err");
      ph[0]++;
      drv(0, 0, gray(ph[0]));
      idle(6);
      wr(0, 0, 32'h1234);
      idle(10);
      rd(0, 0, 32'h1234, "t6_write_beats_step");
      steps(0, 0, 1, 1, 10);
      rd(0, 0, 32'h1235, "t6_decode_resumes");
      for (int k = 0; k < 20 && eq.size() > 0; k++) @(negedge clk);
      if (eq.size() > 0) begin
         $display("FAIL scoreboard_drain actual=%0d required=0", eq.size());
         $fatal(1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
